// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 multiply/divide unit producing a {hi, lo} result
// Multiply support is compiled in only when MULDIV_MUL_EN is defined.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic               annul_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               err_o
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
  logic               sign1_q, sign1_d, sign2_q, sign2_d;
  logic [1:0]         op_q, op_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               err_q, err_d;

  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   quo_s, rem_s;
  logic [2*WIDTH-1:0] mul_res;
`ifdef MULDIV_MUL_EN
  logic [WIDTH:0]     mac;
`endif

  assign mag1 = (op_i[0] && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign mag2 = (op_i[0] && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  // Divide: hi holds the partial remainder, lo shifts the dividend out and the quotient in.
  assign trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, opb_q};

  assign quo_s = (op_q[0] && (sign1_q ^ sign2_q)) ? -lo_q : lo_q;
  assign rem_s = (op_q[0] && sign1_q) ? -hi_q : hi_q;

`ifdef MULDIV_MUL_EN
  // Multiply: lo holds the multiplier, consumed LSB first while the product fills {hi, lo}.
  assign mac     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
  assign mul_res = (op_q[0] && (sign1_q ^ sign2_q)) ? -{hi_q, lo_q} : {hi_q, lo_q};
`else
  assign mul_res = '0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    sign1_d  = sign1_q;
    sign2_d  = sign2_q;
    op_d     = op_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (start_i && !annul_i) begin
          op_d    = op_i;
          sign1_d = op_i[0] & opdata1_i[WIDTH-1];
          sign2_d = op_i[0] & opdata2_i[WIDTH-1];
          err_d   = 1'b0;
          if (op_i[1] && (opdata2_i == '0)) begin
            state_d  = DONE;
            result_d = {opdata1_i, {WIDTH{1'b1}}};
            err_d    = 1'b1;
          end
`ifndef MULDIV_MUL_EN
          else if (!op_i[1]) begin
            state_d  = DONE;
            result_d = '0;
            err_d    = 1'b1;
          end
`endif
          else begin
            state_d = CALC;
            cnt_d   = CW'(WIDTH);
            hi_d    = '0;
            lo_d    = op_i[1] ? mag1 : mag2;
            opb_d   = op_i[1] ? mag2 : mag1;
          end
        end
      end
      CALC: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = SIGN;
`ifdef MULDIV_MUL_EN
          if (!op_q[1]) begin
            hi_d = mac[WIDTH:1];
            lo_d = {mac[0], lo_q[WIDTH-1:1]};
          end else
`endif
          begin
            if (!trial[WIDTH]) begin
              hi_d = trial[WIDTH-1:0];
              lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
              hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
              lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
          end
        end
      end
      SIGN: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          state_d  = DONE;
          result_d = op_q[1] ? {rem_s, quo_s} : mul_res;
          err_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      op_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      sign1_q  <= sign1_d;
      sign2_q  <= sign2_d;
      op_q     <= op_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = (state_q == DONE);
  assign busy_o   = (state_q != IDLE);
  assign err_o    = err_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit against an arithmetic model
// Multiply expectations follow MULDIV_MUL_EN.
module tb_muldiv_unit;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_i, annul_i;
  logic [1:0]     op_i;
  logic [W-1:0]   a_i, b_i;
  logic [2*W-1:0] result_o;
  logic           ready_o, busy_o, err_o;

  logic           start8;
  logic [7:0]     a8, b8;
  logic [15:0]    res8;
  logic           rdy8, busy8, err8;

  int checks = 0;
  int errors = 0;
  logic [63:0] last_exp = '0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) u_dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .annul_i(annul_i),
    .opdata1_i(a_i), .opdata2_i(b_i), .result_o(result_o),
    .ready_o(ready_o), .busy_o(busy_o), .err_o(err_o)
  );

  muldiv_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start_i(start8), .op_i(2'b10), .annul_i(1'b0),
    .opdata1_i(a8), .opdata2_i(b8), .result_o(res8),
    .ready_o(rdy8), .busy_o(busy8), .err_o(err8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {err, result} from plain integer arithmetic
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [31:0]     q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (op[1]) begin
      if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
      if (op[0]) begin
        q = 32'(sa / sb);
        r = 32'(sa % sb);
      end else begin
        q = 32'(ua / ub);
        r = 32'(ua % ub);
      end
      return {1'b0, r, q};
    end
`ifdef MULDIV_MUL_EN
    if (op[0]) return {1'b0, 64'(sa * sb)};
    return {1'b0, 64'(ua * ub)};
`else
    return {1'b1, 64'd0};
`endif
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom());
    endcase
  endfunction

  // Called at a negedge; returns at the negedge of cycle T+1.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [64:0] exp;
    int cyc;
    int lat;
    exp = model(op, a, b);
    lat = exp[64] ? 1 : W + 2;
    issue(op, a, b);
    cyc = 1;
    check({tag, " busy_rise"}, 64'(busy_o), 64'd1);
    if (!exp[64]) check({tag, " err_clr"}, 64'(err_o), 64'd0);
    while (!ready_o && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'(lat));
    check({tag, " result"}, result_o, exp[63:0]);
    check({tag, " err"}, 64'(err_o), 64'(exp[64]));
    last_exp = exp[63:0];
    @(negedge clk);
    check({tag, " busy_fall"}, {62'd0, busy_o, ready_o}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int seen;
    rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; op_i = 2'b00; a_i = '0; b_i = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    check("reset outputs", {result_o[61:0], ready_o, busy_o}, 64'd0);
    check("reset err", 64'(err_o), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    run("udiv 100/7", 2'b10, 32'd100, 32'd7);
    check("udiv 100/7 const", last_exp, {32'd2, 32'd14});
    run("sdiv -7/2", 2'b11, 32'hFFFF_FFF9, 32'd2);
    check("sdiv -7/2 const", last_exp, 64'hFFFF_FFFF_FFFF_FFFD);
    run("sdiv min/-1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    run("div 5/0", 2'b10, 32'd5, 32'd0);
    run("smul -3*5", 2'b01, 32'hFFFF_FFFD, 32'd5);
    run("umul", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run("udiv after err", 2'b10, 32'hFFFF_FFFF, 32'd3);

    // start together with annul in IDLE is dropped
    start_i = 1'b1; annul_i = 1'b1; op_i = 2'b10; a_i = 32'd9; b_i = 32'd0;
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    check("idle annul drop", {62'd0, busy_o, ready_o}, 64'd0);

    // annul mid-divide with an ignored start in T+5
    issue(2'b10, 32'd1000, 32'd3);
    cyc = 1;
    while (cyc < 5) begin @(negedge clk); cyc++; end
    start_i = 1'b1; op_i = 2'b10; a_i = 32'd9; b_i = 32'd0;
    @(negedge clk); cyc++;
    start_i = 1'b0;
    check("ignored start", {62'd0, busy_o, ready_o}, 64'd2);
    while (cyc < 10) begin @(negedge clk); cyc++; end
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    check("annul busy_fall", 64'(busy_o), 64'd0);
    seen = 0;
    repeat (40) begin
      if (ready_o) seen++;
      @(negedge clk);
    end
    check("annul no ready", 64'(seen), 64'd0);
    check("annul result held", result_o, last_exp);

    // asynchronous reset mid-calculation
    issue(2'b11, 32'd12345, 32'd67);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1 check("async reset", {result_o[61:0], ready_o, busy_o}, 64'd0);
    check("async reset err", 64'(err_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run("post-reset 100/7", 2'b10, 32'd100, 32'd7);

    for (int i = 0; i < 40; i++) begin
      run($sformatf("rand%0d", i), 2'($urandom_range(0, 3)), pick(), pick());
    end

    // WIDTH=8 instance
    start8 = 1'b1; a8 = 8'd100; b8 = 8'd7;
    @(negedge clk);
    start8 = 1'b0;
    cyc = 1;
    while (!rdy8 && cyc < 50) begin @(negedge clk); cyc++; end
    check("w8 latency", 64'(cyc), 64'd10);
    check("w8 result", 64'(res8), 64'h020E);
    check("w8 err", 64'(err8), 64'd0);
    @(negedge clk);
    check("w8 busy_fall", 64'(busy8), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
